// File: rtl/mul_pkg.sv
// Shared definitions for the sequential mantissa multiplier: FSM encoding,
// default mantissa width and the iteration-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 24;

  // Counter must hold 0..w-1; keep at least one bit for the smallest width.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/add_row.sv
// WIDTH-bit ripple-carry adder row built from single-bit full-adder cells;
// the carry out becomes the top bit of s.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module add_row #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH:0]   s
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x (x[i]),
      .y (y[i]),
      .ci(carry[i]),
      .s (s[i]),
      .co(carry[i+1])
    );
  end

  assign s[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/seq_mant_mul.sv
// Radix-2 shift-and-add unsigned mantissa multiplier: one partial-product
// row per cycle, WIDTH iterations, start/busy/done handshake.
module seq_mant_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sum;

  add_row #(.WIDTH(WIDTH)) u_add_row (
    .x  (acc_hi),
    .y  (a_reg),
    .cin(1'b0),
    .s  (add_s)
  );

  // Multiplier LSB selects add-multiplicand vs. pass-through of the high half.
  assign sum = acc_lo[0] ? add_s : {1'b0, acc_hi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          // Shift {sum, acc_lo} right by one: the carry lands in acc_hi MSB.
          acc_hi <= sum[WIDTH:1];
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == RUN) || (state == DONE);
  assign done    = (state == DONE);
  assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_seq_mant_mul.sv
// Directed scoreboard bench for seq_mant_mul: stimulus pushes expected
// products, a negedge monitor pops and compares on every done pulse.
module tb_seq_mant_mul;

  localparam int W = 24;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc_edge;
    string          name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   pulses = 0;
  logic prev_done = 1'b0;

  seq_mant_mul #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, both in
  // value and in edges counted from the accepting edge (inclusive) = W+1.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      pulses = pulses + 1;
      chk("single_pulse", {63'd0, prev_done}, 64'd0);
      if (sb.size() == 0) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL unexpected_done: got product 0x%0h expected no done", product);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_product"}, {16'd0, product}, {16'd0, mon_e.prod});
        chk({mon_e.name, "_latency"}, 64'(edge_n - mon_e.acc_edge + 1), 64'(W + 1));
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2*W-1:0] exp, input string name, input bit push);
    exp_t e;
    wait_idle();
    a = av;
    b = bv;
    start = 1'b1;
    if (push) begin
      e.prod = exp;
      e.acc_edge = edge_n + 1;
      e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    #1;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    int   p0;
    int   n;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_reset", {15'd0, busy, done, product}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("idle_outputs", {15'd0, busy, done, product}, 64'd0);
    end

    issue(24'h800000, 24'h800000, 48'h400000000000, "one_x_one", 1'b1);
    wait_drain();
    @(negedge clk);
    chk("idle_after_done_busy", 64'(busy), 64'd0);
    chk("product_held", {16'd0, product}, 64'h400000000000);

    issue(24'hC00000, 24'hC00000, 48'h900000000000, "one5_sq", 1'b1);
    wait_drain();
    issue(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max_sq", 1'b1);
    wait_drain();
    issue(24'hABCDEF, 24'h000000, 48'h0, "zero_b", 1'b1);
    wait_drain();

    // start pulses while busy must be ignored; a held start is taken in IDLE.
    p0 = pulses;
    issue(24'h800000, 24'h800000, 48'h400000000000, "busy_ignore", 1'b1);
    repeat (5) @(negedge clk);
    a = 24'hFFFFFF;
    b = 24'hFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("done_timeout", 64'(done), 64'd1);
    start = 1'b1;
    e.prod = 48'hFFFFFE000001;
    e.acc_edge = edge_n + 2;
    e.name = "held_start";
    sb.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("busy_test_pulses", 64'(pulses - p0), 64'd2);

    issue(24'h123456, 24'h654321, 48'h0, "aborted", 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_run_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {15'd0, busy, done, product}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(24'h000003, 24'h000005, 48'h00000000000F, "after_reset", 1'b1);
    wait_drain();

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
